clk_div_sseg: RTL and testbench

Display-timing front end for the 8-digit multiplexed seven-segment driver. It divides the board clock down to a 1 kHz digit-scan clock, with a companion one-cycle tick. It also decodes a 4-bit hex nibble into active-low segment drive for common-anode digits. The divider is sequential; the decoder path is purely combinational.

---
 rtl/display_pkg.sv | 23 ++
 rtl/clk_div_sseg_if.sv | 14 +
 rtl/hex_sseg_decoder.sv | 33 +++
 rtl/clk_div_sseg.sv | 51 +++++
 tb/tb_clk_div_sseg.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path.
// Segment codes are {g,f,e,d,c,b,a}, active-low (0 = segment lit), common-anode digits.
package display_pkg;

    localparam logic [6:0] SSEG_0     = 7'h40;
    localparam logic [6:0] SSEG_1     = 7'h79;
    localparam logic [6:0] SSEG_2     = 7'h24;
    localparam logic [6:0] SSEG_3     = 7'h30;
    localparam logic [6:0] SSEG_4     = 7'h19;
    localparam logic [6:0] SSEG_5     = 7'h12;
    localparam logic [6:0] SSEG_6     = 7'h02;
    localparam logic [6:0] SSEG_7     = 7'h78;
    localparam logic [6:0] SSEG_8     = 7'h00;
    localparam logic [6:0] SSEG_9     = 7'h10;
    localparam logic [6:0] SSEG_A     = 7'h08;
    localparam logic [6:0] SSEG_B     = 7'h03;
    localparam logic [6:0] SSEG_C     = 7'h46;
    localparam logic [6:0] SSEG_D     = 7'h21;
    localparam logic [6:0] SSEG_E     = 7'h06;
    localparam logic [6:0] SSEG_F     = 7'h0E;
    localparam logic [6:0] SSEG_BLANK = 7'h7F;

endpackage

// File: rtl/clk_div_sseg_if.sv
// Display-timing bundle: hex digit in, divided scan clock, tick and segment drive out.
interface clk_div_sseg_if;

    logic [3:0] num;
    logic       clk_out;
    logic       tick;
    logic [6:0] sseg;

    // Driver of the digit / consumer of the timing outputs
    modport master (output num, input clk_out, input tick, input sseg);
    // The display-timing block itself
    modport slave  (input num, output clk_out, output tick, output sseg);

endinterface

// File: rtl/hex_sseg_decoder.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
module hex_sseg_decoder
    import display_pkg::*;
(
    input  logic [3:0] num,
    output logic [6:0] sseg
);

    // Full case over the nibble; the blank default only guards against X propagation
    always_comb begin
        sseg = SSEG_BLANK;
        case (num)
            4'h0: sseg = SSEG_0;
            4'h1: sseg = SSEG_1;
            4'h2: sseg = SSEG_2;
            4'h3: sseg = SSEG_3;
            4'h4: sseg = SSEG_4;
            4'h5: sseg = SSEG_5;
            4'h6: sseg = SSEG_6;
            4'h7: sseg = SSEG_7;
            4'h8: sseg = SSEG_8;
            4'h9: sseg = SSEG_9;
            4'hA: sseg = SSEG_A;
            4'hB: sseg = SSEG_B;
            4'hC: sseg = SSEG_C;
            4'hD: sseg = SSEG_D;
            4'hE: sseg = SSEG_E;
            4'hF: sseg = SSEG_F;
            default: sseg = SSEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clk_div_sseg.sv
// Display-timing front end: divides clk down to a 50% duty scan clock with a
// one-cycle tick after each rising transition, and decodes the hex digit to segments.
module clk_div_sseg #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned OUT_FREQ_HZ = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_sseg_if.slave  dsp
);

    localparam int unsigned HALF = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    if (HALF < 1) begin : g_bad_half
        $error("clk_div_sseg: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
    end

    logic [CW-1:0] r_cnt;
    logic          r_clk_out;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    // Half-period counter; on wrap toggle clk_out and flag the 0->1 transition as tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            r_tick    <= ~r_clk_out;
        end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_tick    <= 1'b0;
        end
    end

    assign dsp.clk_out = r_clk_out;
    assign dsp.tick    = r_tick;

    hex_sseg_decoder u_dec (
        .num  (dsp.num),
        .sseg (dsp.sseg)
    );

endmodule

// File: tb/tb_clk_div_sseg.sv
// Self-checking bench for clk_div_sseg: a small divider (HALF=5) under random
// reset/digit stimulus and the default divider up to its first scan-clock rise.
module tb_clk_div_sseg;

    localparam int HS = 5;        // small config: 20 Hz / (2*2 Hz)
    localparam int HD = 50000;    // default config: 100 MHz / (2*1 kHz)

    logic clk = 1'b0;
    logic rst_n_s;
    logic rst_n_d;

    always #5 clk = ~clk;

    clk_div_sseg_if if_s ();
    clk_div_sseg_if if_d ();

    clk_div_sseg #(.CLK_FREQ_HZ(20), .OUT_FREQ_HZ(2)) u_small (
        .clk   (clk),
        .rst_n (rst_n_s),
        .dsp   (if_s.slave)
    );

    clk_div_sseg u_dflt (
        .clk   (clk),
        .rst_n (rst_n_d),
        .dsp   (if_d.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: segment pattern per hex digit, and divider outputs as a
    // function of the number of clk edges seen since reset release.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic exp_clk(input int n, input int h);
        return ((n / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int n, input int h);
        return (n >= h) && ((n % (2 * h)) == h);
    endfunction

    // Edges since release for each instance
    int n_s = 0;
    int n_d = 0;
    always @(posedge clk or negedge rst_n_s)
        if (!rst_n_s) n_s <= 0; else n_s <= n_s + 1;
    always @(posedge clk or negedge rst_n_d)
        if (!rst_n_d) n_d <= 0; else n_d <= n_d + 1;

    // Background check of the default instance once it is running
    logic d_run = 1'b0;
    logic d_prev = 1'b0;
    int   d_rises = 0;
    int   d_rise_n = -1;
    always @(negedge clk) begin
        if (d_run) begin
            check("d_clk_out", 32'(if_d.clk_out), 32'(exp_clk(n_d, HD)));
            check("d_tick", 32'(if_d.tick), 32'(exp_tick(n_d, HD)));
            check("d_sseg", 32'(if_d.sseg), 32'(seg_tab[if_d.num]));
            if (if_d.clk_out && !d_prev) begin
                d_rises++;
                if (d_rise_n < 0) d_rise_n = n_d;
            end
            d_prev = if_d.clk_out;
        end
    end

    // One small-instance cycle: check against model at negedge, then new random digits
    task automatic step_s();
        @(negedge clk);
        check("s_clk_out", 32'(if_s.clk_out), 32'(exp_clk(n_s, HS)));
        check("s_tick", 32'(if_s.tick), 32'(exp_tick(n_s, HS)));
        check("s_sseg", 32'(if_s.sseg), 32'(seg_tab[if_s.num]));
        #1;
        if_s.num = 4'($urandom_range(0, 15));
        if_d.num = 4'($urandom_range(0, 15));
    endtask

    // Assert reset a few ns after a rising edge and verify outputs clear before the next edge
    task automatic async_reset_s(input int off_ns, input int hold);
        @(posedge clk);
        #(off_ns);
        rst_n_s = 1'b0;
        #1;
        check("async_clk_out", 32'(if_s.clk_out), 32'd0);
        check("async_tick", 32'(if_s.tick), 32'd0);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        rst_n_s = 1'b1;
    endtask

    initial begin
        int ticks;
        int rises;
        logic prev;

        rst_n_s  = 1'b0;
        rst_n_d  = 1'b0;
        if_s.num = 4'h0;
        if_d.num = 4'h0;

        // Reset hold on both instances
        repeat (10) begin
            @(negedge clk);
            check("rst_d_clk_out", 32'(if_d.clk_out), 32'd0);
            check("rst_d_tick", 32'(if_d.tick), 32'd0);
            check("rst_s_clk_out", 32'(if_s.clk_out), 32'd0);
            check("rst_s_tick", 32'(if_s.tick), 32'd0);
        end

        // Decoder sweep, changed and checked strictly between clk edges
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #2;
            if_s.num = 4'(i);
            if_d.num = 4'(15 - i);
            #1;
            check("sweep_s", 32'(if_s.sseg), 32'(seg_tab[i]));
            check("sweep_d", 32'(if_d.sseg), 32'(seg_tab[15 - i]));
        end

        // Start the default instance running in the background
        @(negedge clk);
        rst_n_d = 1'b1;
        d_run   = 1'b1;

        // Small divider: 40 cycles after release -> 4 rises and 4 ticks
        @(negedge clk);
        rst_n_s = 1'b1;
        ticks = 0;
        rises = 0;
        prev  = 1'b0;
        repeat (40) begin
            step_s();
            if (if_s.tick) ticks++;
            if (if_s.clk_out && !prev) rises++;
            prev = if_s.clk_out;
        end
        check("tick_count", 32'(ticks), 32'd4);
        check("rise_count", 32'(rises), 32'd4);

        // Reset at count 3 of the high phase (edge 8 of the period)
        for (int k = 0; k < 12 && (n_s % (2 * HS)) != 7; k++) step_s();
        check("pre_rst_phase", 32'(n_s % (2 * HS)), 32'd7);
        @(posedge clk);
        #1;
        check("pre_rst_high", 32'(if_s.clk_out), 32'd1);
        #1;
        rst_n_s = 1'b0;
        #1;
        check("mid_rst_clk_out", 32'(if_s.clk_out), 32'd0);
        repeat (3) @(negedge clk);
        rst_n_s = 1'b1;
        repeat (12) step_s();

        // Random runs interleaved with random mid-cycle resets
        repeat (25) begin
            repeat ($urandom_range(1, 30)) step_s();
            async_reset_s(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
        end

        // Keep exercising the small instance until the default one is past its first rise
        for (int k = 0; k < 60000 && n_d < HD + 10; k++) step_s();
        check("d_reached", 32'(n_d >= HD + 10), 32'd1);
        check("d_rises", 32'(d_rises), 32'd1);
        check("d_rise_edge", 32'(d_rise_n), 32'(HD));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
